alu_ctrl: RTL and testbench

Sequencing initiator that drives the 8-bit combinational ALU (S/X/Y/cin in; ans/exceed out) and writes its result back into local storage. Holds a 4 x 8-bit register file and takes one instruction at a time over a valid/ready handshake. For each instruction it presents operands to the ALU, captures the result and overflow, updates the flags and pulses done. It sits between the course-design instruction source (switches/test sequencer) and the ALU.

---
 rtl/alu_ctrl.sv | 127 ++++++++++++
 tb/tb_alu_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// Sequencing controller for the 8-bit combinational ALU: accepts one instruction
// at a time, drives registered ALU operands and writes the result back to a 4x8 register file.
module alu_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_ld,
  input  logic [2:0]       in_op,
  input  logic [1:0]       in_rd,
  input  logic [1:0]       in_rs,
  input  logic [1:0]       in_rt,
  input  logic             in_cin,
  input  logic [7:0]       in_imm,
  output logic [2:0]       alu_S,
  output logic [7:0]       alu_X,
  output logic [7:0]       alu_Y,
  output logic             alu_cin,
  input  logic [7:0]       alu_ans,
  input  logic             alu_exceed,
  output logic             done,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_vs,
  input  logic [1:0]       dbg_sel,
  output logic [7:0]       dbg_data,
  output logic [CNT_W-1:0] retired
);

  // state  | meaning
  // S_IDLE | ready for an instruction
  // S_EXEC | operands on the ALU, result written at the end edge
  // S_DONE | done pulse, retired count bumps at the end edge
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_regs [4];
  logic [1:0]       r_rd;
  logic [2:0]       r_alu_s;
  logic [7:0]       r_alu_x;
  logic [7:0]       r_alu_y;
  logic             r_alu_cin;
  logic             r_flag_z;
  logic             r_flag_v;
  logic             r_flag_vs;
  logic [CNT_W-1:0] r_retired;
  logic             w_accept;
  logic             w_done;

  assign in_ready = (r_state == S_IDLE);
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = in_ld ? S_DONE : S_EXEC;
      S_EXEC: w_state_nxt = S_DONE;
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Reset wins over an in-flight instruction: its write and retire are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
      r_rd      <= '0;
      r_alu_s   <= '0;
      r_alu_x   <= '0;
      r_alu_y   <= '0;
      r_alu_cin <= 1'b0;
      r_flag_z  <= 1'b0;
      r_flag_v  <= 1'b0;
      r_flag_vs <= 1'b0;
      r_retired <= '0;
    end else begin
      if (w_accept) begin
        if (in_ld) begin
          r_regs[in_rd] <= in_imm;
          r_flag_z      <= (in_imm == 8'd0);
          r_flag_v      <= 1'b0;
        end else begin
          r_alu_s   <= in_op;
          r_alu_x   <= r_regs[in_rs];
          r_alu_y   <= r_regs[in_rt];
          r_alu_cin <= in_cin;
          r_rd      <= in_rd;
        end
      end
      if (r_state == S_EXEC) begin
        r_regs[r_rd] <= alu_ans;
        r_flag_z     <= (alu_ans == 8'd0);
        r_flag_v     <= alu_exceed;
        r_flag_vs    <= r_flag_vs | alu_exceed;
      end
      if (r_state == S_DONE) r_retired <= r_retired + 1'b1;
    end
  end

  assign alu_S    = r_alu_s;
  assign alu_X    = r_alu_x;
  assign alu_Y    = r_alu_y;
  assign alu_cin  = r_alu_cin;
  assign done     = w_done;
  assign flag_z   = r_flag_z;
  assign flag_v   = r_flag_v;
  assign flag_vs  = r_flag_vs;
  assign dbg_data = r_regs[dbg_sel];
  assign retired  = r_retired;

endmodule

// File: tb/tb_alu_ctrl.sv
// Randomized self-checking bench for alu_ctrl with a behavioural ALU and
// an instruction-level reference model of the register file and flags.
module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_ld;
  logic [2:0] in_op;
  logic [1:0] in_rd, in_rs, in_rt;
  logic       in_cin;
  logic [7:0] in_imm;
  logic [2:0] alu_S;
  logic [7:0] alu_X, alu_Y;
  logic       alu_cin;
  logic [7:0] alu_ans;
  logic       alu_exceed;
  logic       done, flag_z, flag_v, flag_vs;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;
  logic [7:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_reg [4];
  logic       m_z, m_v, m_vs;
  logic [7:0] m_ret;

  always #5 clk = ~clk;

  alu_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ld(in_ld), .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_cin(in_cin), .in_imm(in_imm), .alu_S(alu_S), .alu_X(alu_X), .alu_Y(alu_Y),
    .alu_cin(alu_cin), .alu_ans(alu_ans), .alu_exceed(alu_exceed), .done(done),
    .flag_z(flag_z), .flag_v(flag_v), .flag_vs(flag_vs), .dbg_sel(dbg_sel),
    .dbg_data(dbg_data), .retired(retired)
  );

  // Course-design ALU: op 100 adds with an extra +1 when cin=0, exceed is signed overflow.
  function automatic logic [8:0] alu_f(input logic [2:0] s, input logic [7:0] x,
                                       input logic [7:0] y, input logic c);
    logic [7:0] r;
    logic       e;
    e = 1'b0;
    case (s)
      3'b000: r = 8'h00;
      3'b001: r = x & y;
      3'b010: r = x | y;
      3'b011: r = x ^ y;
      3'b100: begin
        r = x + y + (c ? 8'd0 : 8'd1);
        e = (x[7] == y[7]) && (r[7] != x[7]);
      end
      3'b101: r = {x[6:0], 1'b0};
      3'b110: r = {1'b0, x[7:1]};
      default: r = {x[7], x[7:1]};
    endcase
    return {e, r};
  endfunction

  always_comb {alu_exceed, alu_ans} = alu_f(alu_S, alu_X, alu_Y, alu_cin);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_z = 1'b0; m_v = 1'b0; m_vs = 1'b0; m_ret = 8'h00;
  endtask

  task automatic model_exec(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                            input logic [1:0] rs, input logic [1:0] rt, input logic cin,
                            input logic [7:0] imm);
    logic [8:0] res;
    if (ld) begin
      m_reg[rd] = imm; m_z = (imm == 8'h00); m_v = 1'b0;
    end else begin
      res = alu_f(op, m_reg[rs], m_reg[rt], cin);
      m_reg[rd] = res[7:0]; m_z = (res[7:0] == 8'h00); m_v = res[8]; m_vs = m_vs | res[8];
    end
    m_ret = m_ret + 8'd1;
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), {24'h0, dbg_data}, {24'h0, m_reg[i]});
    end
    chk({tag, "_z"},   {31'h0, flag_z},  {31'h0, m_z});
    chk({tag, "_v"},   {31'h0, flag_v},  {31'h0, m_v});
    chk({tag, "_vs"},  {31'h0, flag_vs}, {31'h0, m_vs});
    chk({tag, "_ret"}, {24'h0, retired}, {24'h0, m_ret});
  endtask

  task automatic drive(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                       input logic [1:0] rs, input logic [1:0] rt, input logic cin,
                       input logic [7:0] imm);
    in_ld = ld; in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_cin = cin; in_imm = imm;
  endtask

  // Issues one instruction from IDLE and checks cycle-by-cycle handshake timing.
  task automatic issue(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                       input logic [1:0] rs, input logic [1:0] rt, input logic cin,
                       input logic [7:0] imm);
    logic [7:0] old_rd;
    chk("acc_rdy", {31'h0, in_ready}, 32'd1);
    old_rd = m_reg[rd];
    drive(ld, op, rd, rs, rt, cin, imm);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ld) begin
      chk("exec_rdy",  {31'h0, in_ready}, 32'd0);
      chk("exec_done", {31'h0, done},     32'd0);
      chk("exec_x",    {24'h0, alu_X},    {24'h0, m_reg[rs]});
      chk("exec_y",    {24'h0, alu_Y},    {24'h0, m_reg[rt]});
      chk("exec_s",    {29'h0, alu_S},    {29'h0, op});
      dbg_sel = rd; #1;
      chk("exec_old",  {24'h0, dbg_data}, {24'h0, old_rd});
      @(posedge clk); #1;
    end
    model_exec(ld, op, rd, rs, rt, cin, imm);
    chk("done_hi",  {31'h0, done},     32'd1);
    chk("done_rdy", {31'h0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("idle_rdy",  {31'h0, in_ready}, 32'd1);
    chk("idle_done", {31'h0, done},     32'd0);
  endtask

  task automatic rand_issue();
    issue(1'($urandom), 3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
          1'($urandom), 8'($urandom));
  endtask

  task automatic expect_reg(input string tag, input logic [1:0] r, input logic [7:0] v);
    dbg_sel = r; #1;
    chk(tag, {24'h0, dbg_data}, {24'h0, v});
  endtask

  initial begin
    int n_done;
    int cyc;
    logic ld_s; logic [2:0] op_s; logic [1:0] rd_s, rs_s, rt_s; logic cin_s; logic [7:0] imm_s;

    rst = 1'b1; in_valid = 1'b0; dbg_sel = 2'd0;
    drive(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_rdy",  {31'h0, in_ready}, 32'd1);
    chk("rst_done", {31'h0, done},     32'd0);
    chk("rst_alux", {24'h0, alu_X},    32'd0);
    chk("rst_alus", {29'h0, alu_S},    32'd0);
    check_state("rst");

    // ADD overflow, ADD +1 when cin=0, AND to zero
    issue(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h7F);
    issue(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 8'h01);
    issue(1'b0, 3'b100, 2'd2, 2'd0, 2'd1, 1'b1, 8'h00);
    expect_reg("add_r2", 2'd2, 8'h80);
    chk("add_v",  {31'h0, flag_v},  32'd1);
    chk("add_vs", {31'h0, flag_vs}, 32'd1);
    chk("add_z",  {31'h0, flag_z},  32'd0);
    issue(1'b0, 3'b100, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00);
    expect_reg("addc0_r2", 2'd2, 8'h81);
    issue(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h0F);
    issue(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 8'hF0);
    issue(1'b0, 3'b001, 2'd3, 2'd0, 2'd1, 1'b1, 8'h00);
    expect_reg("and_r3", 2'd3, 8'h00);
    chk("and_z",  {31'h0, flag_z},  32'd1);
    chk("and_v",  {31'h0, flag_v},  32'd0);
    chk("and_vs", {31'h0, flag_vs}, 32'd1);
    check_state("dir1");

    // shifts and op 000 on 0x96
    issue(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h96);
    issue(1'b0, 3'b101, 2'd1, 2'd0, 2'd0, 1'b1, 8'h00);
    expect_reg("shl", 2'd1, 8'h2C);
    issue(1'b0, 3'b110, 2'd2, 2'd0, 2'd3, 1'b1, 8'h00);
    expect_reg("shr", 2'd2, 8'h4B);
    issue(1'b0, 3'b111, 2'd3, 2'd0, 2'd1, 1'b1, 8'h00);
    expect_reg("sar", 2'd3, 8'hCB);
    issue(1'b0, 3'b000, 2'd0, 2'd0, 2'd0, 1'b1, 8'h00);
    expect_reg("op0", 2'd0, 8'h00);
    chk("op0_z", {31'h0, flag_z}, 32'd1);
    chk("dir_ret", {24'h0, retired}, 32'd12);
    check_state("dir2");

    for (int k = 0; k < 150; k++) begin
      rand_issue();
      check_state("rnd");
    end

    // in_valid held high with a new instruction after every accept
    n_done = 0;
    in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      ld_s = 1'($urandom); op_s = 3'($urandom); rd_s = 2'($urandom); rs_s = 2'($urandom);
      rt_s = 2'($urandom); cin_s = 1'($urandom); imm_s = 8'($urandom);
      drive(ld_s, op_s, rd_s, rs_s, rt_s, cin_s, imm_s);
      cyc = 0;
      while (!in_ready && cyc < 10) begin
        @(posedge clk); #1;
        if (done) n_done++;
        cyc++;
      end
      if (!in_ready) chk("stream_timeout", {31'h0, in_ready}, 32'd1);
      model_exec(ld_s, op_s, rd_s, rs_s, rt_s, cin_s, imm_s);
      @(posedge clk); #1;
      if (done) n_done++;
    end
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    chk("stream_done", n_done, 32'd40);
    check_state("stream");

    // reset during EXEC of an ADD into R2
    issue(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h7F);
    issue(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 8'h01);
    issue(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 1'b0, 8'h00);
    drive(1'b0, 3'b100, 2'd2, 2'd0, 2'd1, 1'b1, 8'h00);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort_exec", {31'h0, in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("abort_rdy",  {31'h0, in_ready}, 32'd1);
    chk("abort_alux", {24'h0, alu_X},    32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("abort_done", {31'h0, done}, 32'd0);
      @(posedge clk); #1;
    end
    check_state("abort");

    // 256 loads wrap the retired counter back to zero
    for (int k = 0; k < 256; k++) begin
      issue(1'b1, 3'd0, 2'($urandom), 2'd0, 2'd0, 1'b0, 8'($urandom));
      check_state("wrap");
    end
    chk("wrap_zero", {24'h0, retired}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
